// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: issues sprite ROM word reads, using a one-word cache so that adjacent
// pixels in the same word need only one read, and emits palette indices at a fixed latency.
module sprite_pixel_fetch #(
  parameter int unsigned MEM_LATENCY     = 2,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pixel_valid,
  input  logic [20:0] spriteAddress,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic        pix_valid,
  output logic [3:0]  pix_index,
  output logic        pix_opaque,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y
);

  typedef struct packed {
    logic       valid;
    logic       miss;
    logic [1:0] sel;
    logic [9:0] x;
    logic [9:0] y;
  } entry_t;

  logic [18:0] word;
  logic [1:0]  sel;
  logic        hit;
  logic        issue;

  logic        tag_valid_q;
  logic [18:0] tag_q;
  logic [18:0] addr_q;
  logic [15:0] word_q;
  entry_t      dl_q [MEM_LATENCY];
  entry_t      new_entry;
  entry_t      tail;

  logic [15:0] sel_word;
  logic [3:0]  nib;

  logic        pix_valid_q;
  logic [3:0]  pix_index_q;
  logic        pix_opaque_q;
  logic [9:0]  pix_x_q;
  logic [9:0]  pix_y_q;

  assign word  = spriteAddress[20:2];
  assign sel   = spriteAddress[1:0];
  assign hit   = tag_valid_q && (word == tag_q);
  assign issue = pixel_valid && !hit && !Reset;

  assign mem_rd   = issue;
  assign mem_addr = Reset ? '0 : (issue ? word : addr_q);

  assign tail = dl_q[MEM_LATENCY-1];

  always_comb begin
    new_entry       = '0;
    new_entry.valid = pixel_valid;
    new_entry.miss  = issue;
    new_entry.sel   = sel;
    new_entry.x     = DrawX;
    new_entry.y     = DrawY;
  end

  // Reads return in order, so a hit entry always finds its word already in word_q.
  always_comb begin
    sel_word = tail.miss ? mem_data : word_q;
    unique case (tail.sel)
      2'd0:    nib = sel_word[3:0];
      2'd1:    nib = sel_word[7:4];
      2'd2:    nib = sel_word[11:8];
      default: nib = sel_word[15:12];
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_valid_q  <= 1'b0;
      tag_q        <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) dl_q[i] <= '0;
      pix_valid_q  <= 1'b0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      if (issue) begin
        tag_q       <= word;
        tag_valid_q <= 1'b1;
        addr_q      <= word;
      end
      dl_q[0] <= new_entry;
      for (int i = 1; i < int'(MEM_LATENCY); i++) dl_q[i] <= dl_q[i-1];
      if (tail.valid && tail.miss) word_q <= mem_data;
      pix_valid_q  <= tail.valid;
      pix_index_q  <= tail.valid ? nib : 4'h0;
      pix_opaque_q <= tail.valid && (nib != TRANSPARENT_IDX);
      pix_x_q      <= tail.valid ? tail.x : 10'd0;
      pix_y_q      <= tail.valid ? tail.y : 10'd0;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_index  = pix_index_q;
  assign pix_opaque = pix_opaque_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: a per-cycle reference model (fixed ROM contents, fixed output
// latency, single-word read suppression) plus literal checks of the directed scenarios.
module tb_sprite_pixel_fetch;
  localparam int unsigned L = 2;
  localparam logic [3:0]  T = 4'h0;
  localparam int          HN = 1024;

  logic        Clk;
  logic        Reset;
  logic        pixel_valid;
  logic [20:0] spriteAddress;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        pix_opaque;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;

  sprite_pixel_fetch #(.MEM_LATENCY(L), .TRANSPARENT_IDX(T)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .pixel_valid  (pixel_valid),
    .spriteAddress(spriteAddress),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_opaque   (pix_opaque),
    .pix_x        (pix_x),
    .pix_y        (pix_y)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] rom(input logic [18:0] w);
    case (w)
      19'd4776: return 16'hABCD;
      19'd4777: return 16'h1234;
      19'd50:   return 16'h0F00;
      default:  return {~w[7:0], w[7:0]};
    endcase
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] s);
    logic [15:0] t;
    t = d >> {s, 2'b00};
    return t[3:0];
  endfunction

  // Fixed-latency ROM: returns garbage when no read is landing.
  logic        rp_v [L];
  logic [18:0] rp_a [L];
  always @(posedge Clk) begin
    rp_v[0] <= mem_rd;
    rp_a[0] <= mem_addr;
    for (int i = 1; i < int'(L); i++) begin
      rp_v[i] <= rp_v[i-1];
      rp_a[i] <= rp_a[i-1];
    end
  end
  assign mem_data = rp_v[L-1] ? rom(rp_a[L-1]) : 16'hDEAD;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    logic       op;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t        ex [L+1];
  exp_t        nx;
  logic        m_tag_v;
  logic [18:0] m_tag;
  logic [18:0] m_addr;
  logic        m_rd;
  int          cyc;
  int          checks;
  int          errors;

  logic        h_v   [HN];
  logic [3:0]  h_idx [HN];
  logic        h_op  [HN];
  logic [9:0]  h_x   [HN];
  logic [9:0]  h_y   [HN];
  logic        h_rd  [HN];
  logic [18:0] h_ad  [HN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Model: each pixel's result is the ROM nibble, L+1 cycles later; a read is needed only when
  // the word differs from the most recently read one (or nothing has been read since reset).
  always @(posedge Clk) begin
    m_rd = pixel_valid && !Reset && !(m_tag_v && m_tag == spriteAddress[20:2]);
    cyc++;
    if (Reset) begin
      for (int i = 0; i <= int'(L); i++) ex[i] = '{1'b0, 4'h0, 1'b0, 10'd0, 10'd0};
      m_tag_v = 1'b0;
      m_tag   = '0;
      m_addr  = '0;
    end else begin
      nx.v   = pixel_valid;
      nx.idx = pixel_valid ? nibble(rom(spriteAddress[20:2]), spriteAddress[1:0]) : 4'h0;
      nx.op  = pixel_valid && (nx.idx != T);
      nx.x   = pixel_valid ? DrawX : 10'd0;
      nx.y   = pixel_valid ? DrawY : 10'd0;
      for (int i = int'(L); i >= 1; i--) ex[i] = ex[i-1];
      ex[0] = nx;
      if (m_rd) begin
        m_tag_v = 1'b1;
        m_tag   = spriteAddress[20:2];
        m_addr  = spriteAddress[20:2];
      end
    end
  end

  always @(negedge Clk) begin
    logic        e_rd;
    logic [18:0] e_ad;
    if (cyc >= 1) begin
      e_rd = pixel_valid && !Reset && !(m_tag_v && m_tag == spriteAddress[20:2]);
      e_ad = Reset ? 19'd0 : (e_rd ? spriteAddress[20:2] : m_addr);
      chk("mem_rd",     32'(mem_rd),     32'(e_rd));
      chk("mem_addr",   32'(mem_addr),   32'(e_ad));
      chk("pix_valid",  32'(pix_valid),  32'(ex[L].v));
      chk("pix_index",  32'(pix_index),  32'(ex[L].idx));
      chk("pix_opaque", 32'(pix_opaque), 32'(ex[L].op));
      chk("pix_x",      32'(pix_x),      32'(ex[L].x));
      chk("pix_y",      32'(pix_y),      32'(ex[L].y));
      if (cyc < HN) begin
        h_v[cyc]   = pix_valid;
        h_idx[cyc] = pix_index;
        h_op[cyc]  = pix_opaque;
        h_x[cyc]   = pix_x;
        h_y[cyc]   = pix_y;
        h_rd[cyc]  = mem_rd;
        h_ad[cyc]  = mem_addr;
      end
    end
  end

  function automatic int reads(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (h_rd[k] === 1'b1) n++;
    return n;
  endfunction

  task automatic req(input logic v, input logic [20:0] a, input logic [9:0] x, input logic [9:0] y);
    pixel_valid   = v;
    spriteAddress = a;
    DrawX         = x;
    DrawY         = y;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 21'd0, 10'd0, 10'd0);
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    pixel_valid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  logic [3:0] e4 [4];
  int         n0;

  initial begin
    cyc = 0; checks = 0; errors = 0;
    m_tag_v = 1'b0; m_tag = '0; m_addr = '0;
    for (int i = 0; i <= int'(L); i++) ex[i] = '{1'b0, 4'h0, 1'b0, 10'd0, 10'd0};
    Reset = 1'b1; pixel_valid = 1'b0; spriteAddress = '0; DrawX = '0; DrawY = '0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(2);
    chk("rst_pix_valid", 32'(h_v[1]),   32'd0);
    chk("rst_pix_index", 32'(h_idx[1]), 32'd0);
    chk("rst_mem_addr",  32'(h_ad[1]),  32'd0);
    chk("rst_mem_rd",    32'(h_rd[1]),  32'd0);

    // Single miss
    do_reset();
    n0 = cyc;
    req(1'b1, 21'd19105, 10'd100, 10'd50);
    idle(5);
    chk("miss_reads",  32'(reads(n0, n0 + 5)), 32'd1);
    chk("miss_addr",   32'(h_ad[n0]),     32'd4776);
    chk("miss_early",  32'(h_v[n0+2]),    32'd0);
    chk("miss_valid",  32'(h_v[n0+3]),    32'd1);
    chk("miss_index",  32'(h_idx[n0+3]),  32'hC);
    chk("miss_opaque", 32'(h_op[n0+3]),   32'd1);
    chk("miss_x",      32'(h_x[n0+3]),    32'd100);
    chk("miss_y",      32'(h_y[n0+3]),    32'd50);

    // Same-word run
    do_reset();
    n0 = cyc;
    for (int i = 0; i < 4; i++) req(1'b1, 21'(19104 + i), 10'(i), 10'd7);
    idle(5);
    e4 = '{4'hD, 4'hC, 4'hB, 4'hA};
    chk("run_reads", 32'(reads(n0, n0 + 8)), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("run_valid", 32'(h_v[n0+3+k]),   32'd1);
      chk("run_index", 32'(h_idx[n0+3+k]), 32'(e4[k]));
    end

    // Word crossing
    do_reset();
    n0 = cyc;
    for (int i = 0; i < 4; i++) req(1'b1, 21'(19106 + i), 10'(200 + i), 10'd9);
    idle(5);
    e4 = '{4'hB, 4'hA, 4'h4, 4'h3};
    chk("cross_reads", 32'(reads(n0, n0 + 8)), 32'd2);
    chk("cross_rd0",   32'(h_rd[n0]),     32'd1);
    chk("cross_addr0", 32'(h_ad[n0]),     32'd4776);
    chk("cross_rd2",   32'(h_rd[n0+2]),   32'd1);
    chk("cross_addr2", 32'(h_ad[n0+2]),   32'd4777);
    for (int k = 0; k < 4; k++) begin
      chk("cross_valid", 32'(h_v[n0+3+k]),   32'd1);
      chk("cross_index", 32'(h_idx[n0+3+k]), 32'(e4[k]));
    end

    // Transparency
    do_reset();
    n0 = cyc;
    for (int i = 0; i < 3; i++) req(1'b1, 21'(200 + i), 10'd1, 10'd2);
    idle(5);
    chk("tr_valid0",  32'(h_v[n0+3]),  32'd1);
    chk("tr_valid1",  32'(h_v[n0+4]),  32'd1);
    chk("tr_valid2",  32'(h_v[n0+5]),  32'd1);
    chk("tr_opaque0", 32'(h_op[n0+3]), 32'd0);
    chk("tr_opaque1", 32'(h_op[n0+4]), 32'd0);
    chk("tr_opaque2", 32'(h_op[n0+5]), 32'd1);
    chk("tr_index2",  32'(h_idx[n0+5]), 32'hF);

    // Valid gap: word 10 twice with idle cycles between
    do_reset();
    n0 = cyc;
    req(1'b1, 21'd40, 10'd3, 10'd4);
    idle(5);
    req(1'b1, 21'd43, 10'd5, 10'd6);
    idle(5);
    chk("gap_reads",  32'(reads(n0, n0 + 11)), 32'd1);
    chk("gap_index0", 32'(h_idx[n0+3]), 32'hA);
    chk("gap_valid1", 32'(h_v[n0+9]),   32'd1);
    chk("gap_index1", 32'(h_idx[n0+9]), 32'hF);

    // Reset mid-flight (request held valid during the reset cycle)
    do_reset();
    n0 = cyc;
    req(1'b1, 21'd40, 10'd8, 10'd8);
    Reset = 1'b1;
    req(1'b1, 21'd44, 10'd9, 10'd9);
    Reset = 1'b0;
    req(1'b1, 21'd40, 10'd10, 10'd10);
    idle(5);
    for (int k = 1; k <= 4; k++) chk("mid_no_valid", 32'(h_v[n0+k]), 32'd0);
    chk("mid_rd_in_reset", 32'(h_rd[n0+1]),  32'd0);
    chk("mid_fresh_rd",    32'(h_rd[n0+2]),  32'd1);
    chk("mid_fresh_addr",  32'(h_ad[n0+2]),  32'd10);
    chk("mid_valid",       32'(h_v[n0+5]),   32'd1);
    chk("mid_index",       32'(h_idx[n0+5]), 32'hA);
    chk("mid_x",           32'(h_x[n0+5]),   32'd10);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
